// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM state encoding and queue entry type for the fetch stage
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_INST_W = 16;
    localparam int FETCH_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction-memory request bus and decode-side instruction stream
interface instruction_fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead FIFO of fetched instructions tagged with their address
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               clear,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head,
    output logic               head_valid
);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A clear wins over any push or pop presented in the same cycle.
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always @(posedge clock) begin
        if (reset_n) begin
            assert (!(push && !clear && (count_q == CNT_W'(DEPTH))));
        end
    end

    assign count      = count_q;
    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: one outstanding memory request, tagged instruction queue, flush handling
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    pc,
    input  logic                 flush,
    output logic                 pc_advance,
    instruction_fetch_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req;
    logic                req_out;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count;
    logic                head_valid;
    fetch_entry_t        push_entry;
    fetch_entry_t        head;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req        = 1'b0;
        push       = 1'b0;
        pc_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count < CNT_W'(DEPTH)) && !flush) begin
                    req     = 1'b1;
                    addr_d  = pc;
                    state_d = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    state_d = IDLE;
                    if (!flush) begin
                        push       = 1'b1;
                        pc_advance = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            // The request cannot be withdrawn, so a flushed fetch is held until its ack is swallowed.
            DROP: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // The IDLE request is combinational, so it must be masked while reset is held.
    assign req_out       = req & reset_n;
    assign bus.imem_req  = req_out;
    assign bus.imem_addr = !req_out ? '0 : ((state_q == IDLE) ? pc : addr_q);

    assign push_entry = '{addr: addr_q, inst: bus.imem_rdata};
    assign pop        = head_valid & bus.inst_ready;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (flush),
        .count      (count),
        .head       (head),
        .head_valid (head_valid)
    );

    assign bus.inst_valid = head_valid;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic [15:0] pc;
    logic        flush;
    logic        pc_advance;
    int          n_checks;
    int          n_fail;

    instruction_fetch_if #(.ADDR_W(16), .INST_W(16)) bus ();

    instruction_fetch #(.ADDR_W(16), .INST_W(16), .DEPTH(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pc         (pc),
        .flush      (flush),
        .pc_advance (pc_advance),
        .bus        (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        pc             = 16'h0000;
        flush          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.inst_ready = 1'b0;
        settle();
        chk("rst_req",   bus.imem_req,   0);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_adv",   pc_advance,     0);
        chk("rst_addr",  bus.imem_addr,  0);
        chk("rst_inst",  bus.inst,       0);
        step();
        step();

        // First fetch: IDLE request at pc=0, ack one cycle later.
        reset_n = 1'b1;
        settle();
        chk("f0_req",  bus.imem_req,  1);
        chk("f0_addr", bus.imem_addr, 16'h0000);
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
        settle();
        chk("f0_ack_req",  bus.imem_req,  1);
        chk("f0_ack_addr", bus.imem_addr, 16'h0000);
        chk("f0_adv",      pc_advance,    1);
        step();
        bus.imem_ack = 1'b0; pc = 16'h0002;
        settle();
        chk("f0_valid",   bus.inst_valid, 1);
        chk("f0_inst",    bus.inst,       16'h1234);
        chk("f0_inst_pc", bus.inst_pc,    16'h0000);
        chk("f0_adv_off", pc_advance,     0);
        chk("f1_req",     bus.imem_req,   1);
        chk("f1_addr",    bus.imem_addr,  16'h0002);

        // Second fetch fills the queue; no third request until a pop.
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5678;
        settle();
        chk("f1_adv", pc_advance, 1);
        step();
        bus.imem_ack = 1'b0; pc = 16'h0004;
        settle();
        chk("full_req",  bus.imem_req, 0);
        chk("full_head", bus.inst,     16'h1234);
        step();
        chk("full_req2", bus.imem_req, 0);
        bus.inst_ready = 1'b1;
        settle();
        chk("full_pop_req", bus.imem_req, 0);
        step();
        bus.inst_ready = 1'b0;
        settle();
        chk("pop_inst",    bus.inst,      16'h5678);
        chk("pop_inst_pc", bus.inst_pc,   16'h0002);
        chk("f2_req",      bus.imem_req,  1);
        chk("f2_addr",     bus.imem_addr, 16'h0004);

        // Push and pop together with one entry held.
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h9ABC; bus.inst_ready = 1'b1;
        settle();
        chk("pp_adv",  pc_advance, 1);
        chk("pp_head", bus.inst,   16'h5678);
        step();
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; pc = 16'h0006;
        settle();
        chk("pp_valid",   bus.inst_valid, 1);
        chk("pp_inst",    bus.inst,       16'h9ABC);
        chk("pp_inst_pc", bus.inst_pc,    16'h0004);
        chk("f3_addr",    bus.imem_addr,  16'h0006);

        // Flush while waiting; ack arrives three cycles later and is dropped.
        step();
        flush = 1'b1;
        settle();
        chk("fl_req",  bus.imem_req,  1);
        chk("fl_addr", bus.imem_addr, 16'h0006);
        chk("fl_adv",  pc_advance,    0);
        step();
        flush = 1'b0; pc = 16'h0100;
        settle();
        chk("drop_valid", bus.inst_valid, 0);
        chk("drop_req",   bus.imem_req,   1);
        chk("drop_addr",  bus.imem_addr,  16'h0006);
        step();
        chk("drop_addr2", bus.imem_addr, 16'h0006);
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
        settle();
        chk("drop_ack_adv",  pc_advance,    0);
        chk("drop_ack_addr", bus.imem_addr, 16'h0006);
        step();
        bus.imem_ack = 1'b0;
        settle();
        chk("drop_nopush", bus.inst_valid, 0);
        chk("jmp_req",     bus.imem_req,   1);
        chk("jmp_addr",    bus.imem_addr,  16'h0100);

        // Flush coinciding with ack.
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF; flush = 1'b1;
        settle();
        chk("flack_adv", pc_advance, 0);
        step();
        bus.imem_ack = 1'b0; flush = 1'b0; pc = 16'h0200;
        settle();
        chk("flack_valid", bus.inst_valid, 0);
        chk("flack_addr",  bus.imem_addr,  16'h0200);

        // Build up one entry, then assert reset mid-request.
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111;
        settle();
        step();
        bus.imem_ack = 1'b0; pc = 16'h0202;
        settle();
        step();
        settle();
        chk("prerst_valid", bus.inst_valid, 1);
        chk("prerst_req",   bus.imem_req,   1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req",   bus.imem_req,   0);
        chk("arst_valid", bus.inst_valid, 0);
        chk("arst_adv",   pc_advance,     0);
        chk("arst_addr",  bus.imem_addr,  0);
        step();
        reset_n = 1'b1;
        settle();
        chk("rel_req",  bus.imem_req,  1);
        chk("rel_addr", bus.imem_addr, 16'h0202);
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2222;
        settle();
        chk("rel_adv", pc_advance, 1);
        step();
        bus.imem_ack = 1'b0; pc = 16'hFFFE;
        settle();
        chk("rel_inst",    bus.inst,      16'h2222);
        chk("rel_inst_pc", bus.inst_pc,   16'h0202);
        chk("wrap_addr",   bus.imem_addr, 16'hFFFE);

        // Top-of-space address is carried unchanged.
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h3333; bus.inst_ready = 1'b1;
        settle();
        step();
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; pc = 16'h0000;
        settle();
        chk("wrap_inst",    bus.inst,    16'h3333);
        chk("wrap_inst_pc", bus.inst_pc, 16'hFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter: takes the current `pc` and issues a request to instruction memory.
- Buffers returned instructions, tagged with their address, in a small show-ahead queue feeding decode over a valid/ready handshake.
- Pulses `pc_advance` so the PC steps by 2 only when a fetch has actually completed.
- Discards in-flight and buffered work when a jump is taken (`flush`).

Parameters:
- ADDR_W, 16, width of instruction addresses (matches the 16-bit PC).
- INST_W, 16, width of an instruction word.
- DEPTH, 2, number of entries in the output queue (≥1).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current fetch address from the program counter.
- flush  in  1  jump taken this cycle (same signal that drives the PC jump enable).
- pc_advance  out  1  one-cycle pulse; the PC may increment by 2.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1.
- imem_ack  in  1  memory completion; one cycle; rdata valid this cycle.
- imem_rdata  in  INST_W  returned instruction word.
- inst_valid  out  1  queue head valid to decode.
- inst  out  INST_W  instruction at queue head.
- inst_pc  out  ADDR_W  address of instruction at queue head.
- inst_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, queue count=0, all outputs 0. Reset mid-request abandons the request; the memory is reset by the same signal.
- FSM states: IDLE, REQ, DROP.
- IDLE:
  - If count<DEPTH and flush=0: assert imem_req with imem_addr=pc, go REQ.
  - Otherwise stay IDLE with imem_req=0.
  - Request is combinational from state; the address register is loaded on the IDLE→REQ edge.
- REQ:
  - imem_req=1 and imem_addr held until ack; a request is never withdrawn.
  - On imem_ack=1 and flush=0: push {imem_addr, imem_rdata} to the queue, pc_advance=1 in the same cycle, go IDLE.
  - On flush=1 with imem_ack=1: discard data, pc_advance=0, go IDLE.
  - On flush=1 with imem_ack=0: go DROP.
- DROP:
  - imem_req=1 with the same address until ack.
  - On ack: discard data, no pc_advance, go IDLE. A further flush in DROP keeps DROP.
- Latency and throughput:
  - Minimum one request per 2 cycles (IDLE→REQ, ack, IDLE); next request uses the updated pc.
  - Instruction is visible on inst_valid the cycle after its ack.
- Queue:
  - FIFO, show-ahead; inst, inst_pc are the head entry; inst_valid = count>0.
  - Pop when inst_valid & inst_ready. Simultaneous push and pop keeps count unchanged.
  - Outstanding requests ≤1 and issue requires count<DEPTH, so a push never finds the queue full; assertion-checked.
  - flush clears the queue: count=0 next cycle, and any pop that cycle is irrelevant.
- Wrap-around: addresses are carried unchanged; the PC owns increment and wrap (0xFFFE+2=0x0000).
- flush and pc_advance are never 1 in the same cycle.

Decomposition:
- fetch_pkg: ADDR_W/INST_W defaults, FSM state enum (IDLE, REQ, DROP), queue entry struct {addr, inst}.
- One sub-module: fetch_queue (parameterised DEPTH FIFO with push, pop, clear, count, head outputs).

Test Plan:
- Reset then pc=0x0000, ack after 1 cycle with rdata=0x1234 → imem_addr=0x0000, pc_advance pulse at ack, next cycle inst_valid=1, inst=0x1234, inst_pc=0x0000.
- inst_ready=0, DEPTH=2, two fetches complete (0x0000, 0x0002) → no third imem_req until inst_ready=1 pops; then request at pc=0x0004 issued.
- flush in REQ without ack, ack 3 cycles later with rdata=0xDEAD → req held with same addr, state DROP, no push, no pc_advance; next request uses jump target pc=0x0100.
- flush in the same cycle as ack → data discarded, pc_advance=0, queue empty next cycle, inst_valid=0.
- Simultaneous pop and push with count=1 → count stays 1, head advances to the new entry in order.
- reset_n low mid-REQ → imem_req, inst_valid, pc_advance go 0 immediately (async); after release a fresh request to the current pc is issued.
